alu_mdu: RTL and testbench

Parametrised execute-stage ALU with an integrated iterative multiply/divide unit (MDU) and HI/LO registers, for the MIPS-style R-type datapath. It keeps the single-cycle logic, arithmetic and shift operations as combinational results. It adds signed/unsigned compare, multi-cycle MULT/MULTU/DIV/DIVU, and HI/LO moves. A busy/stall handshake lets the pipeline control freeze on MDU hazards.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/mdu_core.sv | 152 +++++++++++++++
 rtl/alu_mdu.sv | 114 +++++++++++
 tb/tb_alu_mdu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its multiply/divide unit:
// operation select encodings, MDU state enum and small decode helpers.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Single-cycle operations (sel[4] = 0)
  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_SLT   = 5'b00100;
  localparam logic [4:0] OP_SLL   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_NOR   = 5'b01010;
  localparam logic [4:0] OP_SLLV  = 5'b01100;
  localparam logic [4:0] OP_SRLV  = 5'b01101;
  localparam logic [4:0] OP_SRAV  = 5'b01110;
  localparam logic [4:0] OP_NOP   = 5'b01111;

  // Multiply/divide and HI/LO operations (sel[4] = 1)
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;
  localparam logic [4:0] OP_SLTU  = 5'b11000;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  // True for the four operations that launch an MDU iteration.
  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  // True for every operation that reads or writes HI/LO (and so must wait for the MDU).
  function automatic logic uses_hilo(input logic [4:0] op);
    return is_mdu_op(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide core. Operands are reduced to magnitudes at
// start, iterated one bit per cycle (shift-add multiply, restoring divide)
// and the signs are re-applied combinationally while in FIN.
module mdu_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q;
  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      cnt_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] work_q;
  logic [2*WIDTH-1:0] work_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic               neg_main_q;  // negate product / quotient
  logic               neg_rem_q;   // negate remainder (dividend was negative)
  logic               div0_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitude of MIN is MIN itself read as unsigned, which the iteration handles.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
    rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    // The true difference is below the divisor, so WIDTH bits are enough.
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      if (rem_ge) begin
        work_d = {rem_diff, work_q[WIDTH-2:0], 1'b1};
      end else begin
        work_d = {rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      work_d = {mul_sum, work_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the finished magnitudes; only observed while done is high.
  always_comb begin
    prod_fix = neg_main_q ? -work_q : work_q;
    quo_fix  = neg_main_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // A zero divisor leaves the dividend magnitude as remainder; re-signing
      // it reproduces data_1 exactly, so only the quotient needs forcing.
      lo = div0_q ? {WIDTH{1'b1}} : quo_fix;
      hi = rem_fix;
    end else begin
      hi = prod_fix[2*WIDTH-1:WIDTH];
      lo = prod_fix[WIDTH-1:0];
    end
  end

  // MDU sequencer: IDLE -> RUN (WIDTH steps) -> FIN -> IDLE, with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MDU_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      div_q      <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (start) begin
            state_q    <= MDU_RUN;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            div_q      <= is_div;
            div0_q     <= is_div & (b == '0);
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= is_div & a_neg;
            if (is_div) begin
              work_q <= {{WIDTH{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              work_q <= {{WIDTH{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
          end
        end
        MDU_RUN: begin
          work_q <= work_d;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= MDU_FIN;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MDU_FIN: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: combinational single-cycle operations, HI/LO registers
// fed by the iterative MDU or by MTHI/MTLO, and the MDU hazard stall decode.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [4:0]       sel,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] mdu_hi;
  logic [WIDTH-1:0] mdu_lo;
  logic             mdu_start;
  logic             mdu_busy;
  logic             mdu_done;
  logic [SHW-1:0]   vshamt;
  logic             slt_res;
  logic             sltu_res;

  // Variable shifts use only the low bits of rs.
  assign vshamt    = data_1[SHW-1:0];
  assign slt_res   = ($signed(data_1) < $signed(data_2));
  assign sltu_res  = (data_1 < data_2);

  // An MDU op starts only when real and the unit is free; otherwise it stalls.
  assign mdu_start = valid & is_mdu_op(sel) & ~mdu_busy;
  assign stall     = valid & mdu_busy & uses_hilo(sel);
  assign busy      = mdu_busy;
  assign done      = mdu_done;

  mdu_core #(
    .WIDTH(WIDTH)
  ) u_mdu_core (
    .clk       (clk),
    .rst       (rst),
    .start     (mdu_start),
    .is_div    (sel[1]),
    .is_signed (~sel[0]),
    .a         (data_1),
    .b         (data_2),
    .busy      (mdu_busy),
    .done      (mdu_done),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  // HI/LO next state: MDU result in FIN, else MTHI/MTLO when the MDU is free.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mdu_done) begin
      hi_d = mdu_hi;
      lo_d = mdu_lo;
    end else if (valid && !mdu_busy) begin
      if (sel == OP_MTHI) begin
        hi_d = data_1;
      end
      if (sel == OP_MTLO) begin
        lo_d = data_1;
      end
    end
  end

  // HI/LO storage, cleared by reset (also when an iteration is aborted).
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Combinational result mux; MDU launches and HI/LO writes return 0.
  always_comb begin
    alu_out = '0;
    case (sel)
      OP_AND:  alu_out = data_1 & data_2;
      OP_OR:   alu_out = data_1 | data_2;
      OP_ADD:  alu_out = data_1 + data_2;
      OP_SUB:  alu_out = data_1 - data_2;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt_res};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, sltu_res};
      OP_SLL:  alu_out = data_2 << shamt;
      OP_SRL:  alu_out = data_2 >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(data_2) >>> shamt);
      OP_XOR:  alu_out = data_1 ^ data_2;
      OP_NOR:  alu_out = ~(data_1 | data_2);
      OP_SLLV: alu_out = data_2 << vshamt;
      OP_SRLV: alu_out = data_2 >> vshamt;
      OP_SRAV: alu_out = $unsigned($signed(data_2) >>> vshamt);
      OP_MFHI: alu_out = hi_q;
      OP_MFLO: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expected results, monitors
// pop and compare when the DUT presents an unstalled result or a done pulse.
`timescale 1ns/1ps
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        valid  = 1'b0;
  logic [4:0]  sel    = OP_NOP;
  logic [31:0] data_1 = '0;
  logic [31:0] data_2 = '0;
  logic [4:0]  shamt  = '0;
  logic [31:0] alu_out;
  logic        busy, done, stall;

  // 8-bit instance
  logic        valid8 = 1'b0;
  logic [4:0]  sel8   = OP_NOP;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic [2:0]  sh8    = '0;
  logic [7:0]  out8;
  logic        busy8, done8, stall8;

  alu_mdu #(.WIDTH(W)) u_dut32 (
    .clk(clk), .rst(rst), .valid(valid), .sel(sel), .data_1(data_1),
    .data_2(data_2), .shamt(shamt), .alu_out(alu_out), .busy(busy),
    .done(done), .stall(stall)
  );

  alu_mdu #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst(rst), .valid(valid8), .sel(sel8), .data_1(a8),
    .data_2(b8), .shamt(sh8), .alu_out(out8), .busy(busy8),
    .done(done8), .stall(stall8)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp8_q[$];
  int   done_q[$];
  int   done8_q[$];
  bit   take  = 1'b0;
  bit   take8 = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitors: result compare when presented and not stalled; done-cycle compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid && take && !stall) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL result32: unexpected result 0x%08h with empty queue", alu_out);
        end else begin
          e = exp_q.pop_front();
          check(e.name, alu_out, e.val);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL done32: unexpected done pulse at cycle %0d", cyc);
        end else begin
          check("done32_cycle", cyc, done_q.pop_front());
        end
      end
      if (valid8 && take8 && !stall8) begin
        if (exp8_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL result8: unexpected result 0x%02h with empty queue", out8);
        end else begin
          e = exp8_q.pop_front();
          check(e.name, {24'h0, out8}, e.val);
        end
      end
      if (done8) begin
        if (done8_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL done8: unexpected done pulse at cycle %0d", cyc);
        end else begin
          check("done8_cycle", cyc, done8_q.pop_front());
        end
      end
    end
  end

  // Present one instruction, hold it while stalled, retire it at the next edge.
  task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit chk, input logic [31:0] e,
                       input string name, output int stalls);
    exp_t x;
    sel = s; data_1 = a; data_2 = b; shamt = sh; valid = 1'b1; take = chk;
    if (chk) begin
      x.name = name; x.val = e;
      exp_q.push_back(x);
    end
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) begin
      n_checks++; n_errors++;
      $display("FAIL %s: stall never released", name);
    end
    @(posedge clk); #1;
    if (is_mdu_op(s)) done_q.push_back(cyc + W);
    valid = 1'b0; take = 1'b0;
  endtask

  task automatic issue8(input logic [4:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh, input bit chk, input logic [7:0] e,
                        input string name);
    exp_t x;
    int   n;
    sel8 = s; a8 = a; b8 = b; sh8 = sh; valid8 = 1'b1; take8 = chk;
    if (chk) begin
      x.name = name; x.val = {24'h0, e};
      exp8_q.push_back(x);
    end
    n = 0;
    @(negedge clk);
    while (stall8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (is_mdu_op(s)) done8_q.push_back(cyc + W8);
    valid8 = 1'b0; take8 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_busy8", {31'h0, busy8}, 32'h0);
    @(posedge clk); #1;
    issue(OP_MFHI, 0, 0, 0, 1, 32'h0, "reset_hi", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'h0, "reset_lo", st);

    // Single-cycle sweep
    issue(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 32'hF000F000, "and", st);
    issue(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 32'hFFF0FFF0, "or", st);
    issue(OP_ADD,  32'hFFFFFFFF, 32'h00000002, 0, 1, 32'h00000001, "add_wrap", st);
    issue(OP_SUB,  32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, "sub_wrap", st);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000001, "slt_neg", st);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000000, "sltu_big", st);
    issue(OP_SLL,  32'h0, 32'h00000001, 31, 1, 32'h80000000, "sll_31", st);
    issue(OP_SRL,  32'h0, 32'h80000000, 4,  1, 32'h08000000, "srl_4", st);
    issue(OP_SRA,  32'h0, 32'h80000000, 4,  1, 32'hF8000000, "sra_4", st);
    issue(OP_XOR,  32'hAAAAAAAA, 32'hFFFF0000, 0, 1, 32'h5555AAAA, "xor", st);
    issue(OP_NOR,  32'h0, 32'h0, 0, 1, 32'hFFFFFFFF, "nor_zero", st);
    issue(OP_SLLV, 32'h00000021, 32'h00000003, 0, 1, 32'h00000006, "sllv_upper_ignored", st);
    issue(OP_SRLV, 32'h00000024, 32'h000000F0, 0, 1, 32'h0000000F, "srlv_4", st);
    issue(OP_SRAV, 32'h00000023, 32'h80000000, 0, 1, 32'hF0000000, "srav_3", st);
    issue(OP_NOP,  32'h12345678, 32'h9ABCDEF0, 7, 1, 32'h0, "nop", st);
    issue(5'b11111, 32'h12345678, 32'h9ABCDEF0, 7, 1, 32'h0, "undefined_sel", st);

    // MULT -3 x 7, then MFLO right behind it stalls through busy
    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 0, 1, 32'h0, "mult_out_zero", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'hFFFFFFEB, "mult_lo", st);
    check("mflo_stall_cycles", st, 32'd33);
    issue(OP_MFHI, 0, 0, 0, 1, 32'hFFFFFFFF, "mult_hi", st);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 0, 0, 32'h0, "multu", st);
    issue(OP_MFHI, 0, 0, 0, 1, 32'h00000001, "multu_hi", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'hFFFFFFFE, "multu_lo", st);

    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 0, 0, 32'h0, "div", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'hFFFFFFFD, "div_m7_2_lo", st);
    issue(OP_MFHI, 0, 0, 0, 1, 32'hFFFFFFFF, "div_m7_2_hi", st);

    issue(OP_DIVU, 32'h00000007, 32'h00000000, 0, 0, 32'h0, "divu0", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'hFFFFFFFF, "divu_by0_lo", st);
    issue(OP_MFHI, 0, 0, 0, 1, 32'h00000007, "divu_by0_hi", st);

    issue(OP_DIV, 32'hFFFFFFFB, 32'h00000000, 0, 0, 32'h0, "div0", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'hFFFFFFFF, "div_by0_lo", st);
    issue(OP_MFHI, 0, 0, 0, 1, 32'hFFFFFFFB, "div_by0_hi", st);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, "divmin", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'h80000000, "div_min_m1_lo", st);
    issue(OP_MFHI, 0, 0, 0, 1, 32'h00000000, "div_min_m1_hi", st);

    // Hazards: ADD runs during busy, MTHI is held off, valid=0 never stalls
    issue(OP_MULT, 32'h00000006, 32'h00000007, 0, 0, 32'h0, "mult_6x7", st);
    issue(OP_ADD, 32'h00000005, 32'h00000006, 0, 1, 32'h0000000B, "add_during_busy", st);
    check("add_during_busy_stalls", st, 32'd0);
    sel = OP_MTHI; data_1 = 32'h00001234; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mthi_busy_stall", {31'h0, stall}, 32'h1);
    end
    @(posedge clk); #1;
    sel = OP_MFLO; valid = 1'b0;
    @(negedge clk);
    check("invalid_never_stalls", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    issue(OP_MFHI, 0, 0, 0, 1, 32'h00000000, "mthi_ignored_hi", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'h0000002A, "mult_6x7_lo", st);

    // MTHI/MTLO when idle; valid=0 writes and launches do nothing
    issue(OP_MTHI, 32'hDEADBEEF, 0, 0, 0, 32'h0, "mthi", st);
    issue(OP_MTLO, 32'h0BADF00D, 0, 0, 0, 32'h0, "mtlo", st);
    sel = OP_MTLO; data_1 = 32'h00000055; valid = 1'b0;
    @(posedge clk); #1;
    sel = OP_MULT; data_1 = 32'h3; data_2 = 32'h3;
    @(posedge clk); #1;
    @(negedge clk);
    check("invalid_mult_no_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    issue(OP_MFHI, 0, 0, 0, 1, 32'hDEADBEEF, "mthi_hi", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'h0BADF00D, "mtlo_lo", st);

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd100, 32'd7, 0, 0, 32'h0, "div_abort", st);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    done_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    issue(OP_MFHI, 0, 0, 0, 1, 32'h0, "abort_hi", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'h0, "abort_lo", st);
    repeat (40) @(posedge clk);
    #1;
    issue(OP_MULT, 32'h00010000, 32'h00010000, 0, 0, 32'h0, "mult_after_abort", st);
    issue(OP_MFHI, 0, 0, 0, 1, 32'h00000001, "post_abort_hi", st);
    issue(OP_MFLO, 0, 0, 0, 1, 32'h00000000, "post_abort_lo", st);

    // WIDTH=8 instance
    issue8(OP_SRA, 8'h00, 8'h80, 3'd7, 1, 8'hFF, "sra8_7");
    issue8(OP_MULT, 8'h80, 8'h80, 3'd0, 1, 8'h00, "mult8_out_zero");
    n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mult8_busy_cycles", n, 32'd9);
    @(posedge clk); #1;
    issue8(OP_MFHI, 0, 0, 0, 1, 8'h40, "mult8_hi");
    issue8(OP_MFLO, 0, 0, 0, 1, 8'h00, "mult8_lo");
    issue8(OP_MULTU, 8'hFF, 8'hFF, 0, 0, 8'h00, "multu8");
    issue8(OP_MFHI, 0, 0, 0, 1, 8'hFE, "multu8_hi");
    issue8(OP_MFLO, 0, 0, 0, 1, 8'h01, "multu8_lo");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size() + exp8_q.size(), 32'd0);
    check("done_queue_drained", done_q.size() + done8_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
